// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch sequencer (imem_fetch_ctrl)
// and its prefetch queue (fetch_queue).
//
// Contents:
//   fetch_state_t     : sequencer states RUN / HALTED / TRAP
//   INSTR_W           : instruction word width
//   PC_STEP           : sequential PC increment in bytes
//   DEFAULT_RESET_PC  : default reset PC
//   pc_advance()      : next sequential PC (wraps modulo 2^32)
// ---------------------------------------------------------------------------
package fetch_pkg;

   localparam int          INSTR_W          = 32;
   localparam logic [31:0] PC_STEP          = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      HALTED = 2'd1,
      TRAP   = 2'd2
   } fetch_state_t;

   // Plain 32-bit add: 32'hFFFF_FFFC rolls over to 32'h0000_0000.
   function automatic logic [31:0] pc_advance(input logic [31:0] pc);
      return pc + PC_STEP;
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// DEPTH-entry prefetch FIFO of {pc, instr} pairs.
//
// Built as a shift register whose entry 0 is always the head, so the head
// outputs come straight from flops. When the queue runs empty the head
// data is not cleared: it keeps showing the last head (stale value).
// Flush wins over push and pop.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   push, push_pc,
//   push_instr          : write one entry at the tail
//   pop                 : drop the head entry (ignored when empty)
//   flush               : discard every entry
//   head_valid          : head entry is valid (registered)
//   head_pc, head_instr : head entry contents (registered)
//   count               : number of valid entries
//   full, empty         : count == DEPTH / count == 0
// ---------------------------------------------------------------------------
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic [31:0]                  push_pc,
   input  logic [INSTR_W-1:0]           push_instr,
   input  logic                         pop,
   input  logic                         flush,
   output logic                         head_valid,
   output logic [31:0]                  head_pc,
   output logic [INSTR_W-1:0]           head_instr,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);

   localparam int CW = $clog2(DEPTH+1);

   logic [31:0]        ent_pc    [DEPTH];
   logic [INSTR_W-1:0] ent_instr [DEPTH];
   logic [DEPTH-1:0]   ent_vld;

   logic [31:0]        nxt_pc    [DEPTH];
   logic [INSTR_W-1:0] nxt_instr [DEPTH];
   logic [DEPTH-1:0]   nxt_vld;

   logic [CW-1:0]      cnt;
   logic [CW-1:0]      cnt_nxt;
   logic [CW-1:0]      wr_idx;
   logic               do_pop;
   logic               do_push;

   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign do_pop  = pop && !empty;
   // A full queue can still accept a push when the head leaves this cycle.
   assign do_push = push && (!full || do_pop);
   assign wr_idx  = do_pop ? (cnt - CW'(1)) : cnt;

   always_comb begin
      nxt_pc    = ent_pc;
      nxt_instr = ent_instr;
      nxt_vld   = ent_vld;
      cnt_nxt   = cnt;
      if (flush) begin
         nxt_vld = '0;
         cnt_nxt = '0;
      end else begin
         if (do_pop) begin
            for (int i = 0; i < DEPTH-1; i++) begin
               // Only move real data down so an emptied head keeps its stale value.
               if (ent_vld[i+1]) begin
                  nxt_pc[i]    = ent_pc[i+1];
                  nxt_instr[i] = ent_instr[i+1];
               end
               nxt_vld[i] = ent_vld[i+1];
            end
            nxt_vld[DEPTH-1] = 1'b0;
         end
         if (do_push) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (wr_idx == CW'(i)) begin
                  nxt_pc[i]    = push_pc;
                  nxt_instr[i] = push_instr;
                  nxt_vld[i]   = 1'b1;
               end
            end
         end
         cnt_nxt = cnt + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_pc[i]    <= '0;
            ent_instr[i] <= '0;
         end
         ent_vld <= '0;
         cnt     <= '0;
      end else begin
         ent_pc    <= nxt_pc;
         ent_instr <= nxt_instr;
         ent_vld   <= nxt_vld;
         cnt       <= cnt_nxt;
      end
   end

   assign head_valid = ent_vld[0];
   assign head_pc    = ent_pc[0];
   assign head_instr = ent_instr[0];
   assign count      = cnt;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// imem_fetch_ctrl
// Instruction fetch sequencer for the RV32I core. Owns the PC, drives the
// combinational instruction memory address, captures {pc, instr} into the
// prefetch queue and presents the head to decode over valid/ready.
// Handles redirects (flush + PC load), level-sensitive halt and, optionally,
// misaligned redirect trapping.
//
// Build option:
//   FETCH_MISALIGN_TRAP_EN defined   : misaligned redirect enters TRAP and
//                                      raises misalign_trap
//   FETCH_MISALIGN_TRAP_EN undefined : redirect_pc[1:0] forced to 0 on load,
//                                      misalign_trap tied 0
//
// Parameters:
//   RESET_PC : PC loaded on reset
//   DEPTH    : prefetch queue entries (>= 2)
//
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   imem_addr / imem_instr     : instruction memory address (PC flop) / data
//   redirect_valid/redirect_pc : PC change request from execute
//   halt                       : stop issuing new fetches (level)
//   id_valid/id_instr/id_pc    : queue head towards decode
//   id_ready                   : decode accepts the head
//   misalign_trap              : misaligned redirect captured
//
// state  | meaning
// -------+-----------------------------------------------------------------
// RUN    | fetching: one push per cycle while the queue has room
// HALTED | halt held: no pushes, PC frozen, queue keeps draining
// TRAP   | misaligned redirect seen: no pushes until reset or aligned redirect
// ---------------------------------------------------------------------------
module imem_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          DEPTH    = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic [31:0]         imem_addr,
   input  logic [INSTR_W-1:0]  imem_instr,
   input  logic                redirect_valid,
   input  logic [31:0]         redirect_pc,
   input  logic                halt,
   output logic                id_valid,
   output logic [INSTR_W-1:0]  id_instr,
   output logic [31:0]         id_pc,
   input  logic                id_ready,
   output logic                misalign_trap
);

   fetch_state_t                state;
   logic [31:0]                 pc;
   logic [31:0]                 pc_target;
   logic                        redirect_misaligned;
   logic                        pop;
   logic                        push;
   logic                        q_full;
   logic                        q_empty;
   logic [$clog2(DEPTH+1)-1:0]  q_count;
   logic                        unused_q_count;

`ifdef FETCH_MISALIGN_TRAP_EN
   assign redirect_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
   assign pc_target           = redirect_pc;
`else
   assign redirect_misaligned = 1'b0;
   assign pc_target           = redirect_pc & ~32'h0000_0003;
`endif

   // Occupancy is only needed as full/empty here.
   assign unused_q_count = ^q_count;

   assign pop  = id_ready && !q_empty;
   assign push = (state == RUN) && !halt && !redirect_valid && (!q_full || pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
         pc    <= RESET_PC;
`ifdef FETCH_MISALIGN_TRAP_EN
         misalign_trap <= 1'b0;
`endif
      end else begin
         if (redirect_valid) begin
            pc <= pc_target;
         end else if (push) begin
            pc <= pc_advance(pc);
         end

         case (state)
            TRAP: begin
               if (redirect_valid && !redirect_misaligned) begin
                  state <= halt ? HALTED : RUN;
               end
            end
            default: begin
               if (redirect_misaligned) begin
                  state <= TRAP;
               end else begin
                  state <= halt ? HALTED : RUN;
               end
            end
         endcase

`ifdef FETCH_MISALIGN_TRAP_EN
         // Mirrors "next state is TRAP" so the flag is a plain flop output.
         misalign_trap <= redirect_valid ? redirect_misaligned : (state == TRAP);
`endif
      end
   end

`ifndef FETCH_MISALIGN_TRAP_EN
   assign misalign_trap = 1'b0;
`endif

   assign imem_addr = pc;

   fetch_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .push_pc    (pc),
      .push_instr (imem_instr),
      .pop        (pop),
      .flush      (redirect_valid),
      .head_valid (id_valid),
      .head_pc    (id_pc),
      .head_instr (id_instr),
      .count      (q_count),
      .full       (q_full),
      .empty      (q_empty)
   );

endmodule
